// File: rtl/interval_timer_arbiter.sv
// Round-robin sequencer that shares one down-counter between two requesters,
// loading the winner's interval, counting it down and pulsing done on completion.
module interval_timer_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req,
   input  logic [WIDTH-1:0] len0,
   input  logic [WIDTH-1:0] len1,
   output logic [1:0]       grant,
   output logic [1:0]       done,
   output logic             busy,
   output logic [WIDTH-1:0] count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       grant_q, grant_d;
   logic [1:0]       done_q, done_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             ptr_q, ptr_d;

   logic             win;
   logic [1:0]       win_oh;
   logic [WIDTH-1:0] win_len;
   logic             own;

   // A tie goes to the pointer; a lone request wins regardless of it.
   assign win     = (req == 2'b11) ? ptr_q : req[1];
   assign win_oh  = win ? 2'b10 : 2'b01;
   assign win_len = win ? len1 : len0;
   assign own     = grant_q[1];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of process ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (req != 2'b00) state_d = (win_len != '0) ? RUN : DONE;
         RUN: begin
            if (!req[own])                 state_d = IDLE;
            else if (count_q == WIDTH'(1)) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      grant_d = grant_q;
      done_d  = 2'b00;
      count_d = count_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (req != 2'b00) begin
               grant_d = win_oh;
               count_d = win_len;
               if (win_len == '0) done_d = win_oh;
            end
         end
         RUN: begin
            // Abort wins over the decrement and hands the tie to the other side.
            if (!req[own]) begin
               grant_d = 2'b00;
               count_d = '0;
               ptr_d   = ~own;
            end else if (count_q == WIDTH'(1)) begin
               count_d = '0;
               done_d  = grant_q;
            end else begin
               count_d = count_q - WIDTH'(1);
            end
         end
         DONE: begin
            grant_d = 2'b00;
            ptr_d   = ~own;
         end
         default: begin
            grant_d = 2'b00;
            count_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant_q <= 2'b00;
         done_q  <= 2'b00;
         count_q <= '0;
         ptr_q   <= 1'b0;
      end else begin
         grant_q <= grant_d;
         done_q  <= done_d;
         count_q <= count_d;
         ptr_q   <= ptr_d;
      end
   end

   assign grant = grant_q;
   assign done  = done_q;
   assign busy  = (state_q != IDLE);
   assign count = count_q;

endmodule

// File: tb/tb_interval_timer_arbiter.sv
// Directed bench for interval_timer_arbiter: a vector table of per-edge
// expectations plus hand-written async-reset and maximum-length sequences.
module tb_interval_timer_arbiter;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst;
   logic [1:0]       req;
   logic [WIDTH-1:0] len0;
   logic [WIDTH-1:0] len1;
   logic [1:0]       grant;
   logic [1:0]       done;
   logic             busy;
   logic [WIDTH-1:0] count;

   int n_checks = 0;
   int n_fails  = 0;

   interval_timer_arbiter #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .len0  (len0),
      .len1  (len1),
      .grant (grant),
      .done  (done),
      .busy  (busy),
      .count (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One row: optional reset before, inputs for the next edge, outputs after it.
   typedef struct {
      bit               rst_first;
      logic [1:0]       req;
      logic [WIDTH-1:0] len0;
      logic [WIDTH-1:0] len1;
      logic [1:0]       grant;
      logic [1:0]       done;
      logic             busy;
      logic [WIDTH-1:0] count;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input bit rf, input logic [1:0] r, input logic [WIDTH-1:0] l0,
                      input logic [WIDTH-1:0] l1, input logic [1:0] g, input logic [1:0] d,
                      input logic b, input logic [WIDTH-1:0] c);
      vec_t v;
      v.rst_first = rf; v.req = r; v.len0 = l0; v.len1 = l1;
      v.grant = g; v.done = d; v.busy = b; v.count = c;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Packed {grant, done, busy, count} so one comparison covers a whole cycle.
   function automatic logic [31:0] pack(input logic [1:0] g, input logic [1:0] d,
                                        input logic b, input logic [WIDTH-1:0] c);
      return {19'd0, g, d, b, c};
   endfunction

   function automatic logic [31:0] outs();
      return pack(grant, done, busy, count);
   endfunction

   task automatic do_reset();
      rst = 1'b0;
      req = 2'b00;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic step(input logic [1:0] r, input logic [WIDTH-1:0] l0, input logic [WIDTH-1:0] l1);
      req = r; len0 = l0; len1 = l1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; req = 2'b00; len0 = '0; len1 = '0;
      #2;
      check("reset_state", outs(), pack(2'b00, 2'b00, 1'b0, 8'd0));
      @(posedge clk);
      #1;
      check("reset_hold", outs(), pack(2'b00, 2'b00, 1'b0, 8'd0));
      rst = 1'b1;

      // Single request, len0=3.
      add(1, 2'b01, 8'd3, 8'd0, 2'b01, 2'b00, 1, 8'd3);
      add(0, 2'b01, 8'd3, 8'd0, 2'b01, 2'b00, 1, 8'd2);
      add(0, 2'b01, 8'd3, 8'd0, 2'b01, 2'b00, 1, 8'd1);
      add(0, 2'b01, 8'd3, 8'd0, 2'b01, 2'b01, 1, 8'd0);
      add(0, 2'b00, 8'd3, 8'd0, 2'b00, 2'b00, 0, 8'd0);
      // Simultaneous requests: 0 first, idle gap, then 1, then back to 0.
      add(1, 2'b11, 8'd2, 8'd5, 2'b01, 2'b00, 1, 8'd2);
      add(0, 2'b11, 8'd2, 8'd5, 2'b01, 2'b00, 1, 8'd1);
      add(0, 2'b11, 8'd2, 8'd5, 2'b01, 2'b01, 1, 8'd0);
      add(0, 2'b11, 8'd2, 8'd5, 2'b00, 2'b00, 0, 8'd0);
      add(0, 2'b11, 8'd2, 8'd5, 2'b10, 2'b00, 1, 8'd5);
      add(0, 2'b11, 8'd2, 8'd5, 2'b10, 2'b00, 1, 8'd4);
      add(0, 2'b11, 8'd2, 8'd5, 2'b10, 2'b00, 1, 8'd3);
      add(0, 2'b11, 8'd2, 8'd5, 2'b10, 2'b00, 1, 8'd2);
      add(0, 2'b11, 8'd2, 8'd5, 2'b10, 2'b00, 1, 8'd1);
      add(0, 2'b11, 8'd2, 8'd5, 2'b10, 2'b10, 1, 8'd0);
      add(0, 2'b11, 8'd2, 8'd5, 2'b00, 2'b00, 0, 8'd0);
      add(0, 2'b11, 8'd2, 8'd5, 2'b01, 2'b00, 1, 8'd2);
      // Zero length on requester 1.
      add(1, 2'b10, 8'd9, 8'd0, 2'b10, 2'b10, 1, 8'd0);
      add(0, 2'b00, 8'd9, 8'd0, 2'b00, 2'b00, 0, 8'd0);
      // Abort at count=6, then pending requester 1 accepted at the next edge.
      add(1, 2'b01, 8'd10, 8'd3, 2'b01, 2'b00, 1, 8'd10);
      add(0, 2'b01, 8'd10, 8'd3, 2'b01, 2'b00, 1, 8'd9);
      add(0, 2'b01, 8'd10, 8'd3, 2'b01, 2'b00, 1, 8'd8);
      add(0, 2'b01, 8'd10, 8'd3, 2'b01, 2'b00, 1, 8'd7);
      add(0, 2'b01, 8'd10, 8'd3, 2'b01, 2'b00, 1, 8'd6);
      add(0, 2'b10, 8'd10, 8'd3, 2'b00, 2'b00, 0, 8'd0);
      add(0, 2'b10, 8'd10, 8'd3, 2'b10, 2'b00, 1, 8'd3);
      add(0, 2'b00, 8'd10, 8'd3, 2'b00, 2'b00, 0, 8'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst_first) do_reset();
         step(vecs[i].req, vecs[i].len0, vecs[i].len1);
         check($sformatf("vec[%0d]", i), outs(),
               pack(vecs[i].grant, vecs[i].done, vecs[i].busy, vecs[i].count));
      end

      // Async reset mid-run at count=4, no clock edge needed.
      do_reset();
      step(2'b01, 8'd8, 8'd0);
      for (int i = 0; i < 4; i++) step(2'b01, 8'd8, 8'd0);
      check("pre_reset_count", outs(), pack(2'b01, 2'b00, 1'b1, 8'd4));
      #2;
      rst = 1'b0;
      #1;
      check("async_reset", outs(), pack(2'b00, 2'b00, 1'b0, 8'd0));
      @(posedge clk);
      #1;
      check("reset_held", outs(), pack(2'b00, 2'b00, 1'b0, 8'd0));
      rst = 1'b1;
      step(2'b11, 8'd5, 8'd6);
      check("post_reset_tie", outs(), pack(2'b01, 2'b00, 1'b1, 8'd5));

      // Maximum length with len1 changed after accept: no wrap, done in cycle 256.
      do_reset();
      step(2'b10, 8'd0, 8'd255);
      check("max_accept", outs(), pack(2'b10, 2'b00, 1'b1, 8'd255));
      for (int i = 1; i <= 254; i++) begin
         step(2'b10, 8'd0, 8'd7);
         check($sformatf("max_count[%0d]", i), outs(),
               pack(2'b10, 2'b00, 1'b1, 8'(255 - i)));
      end
      step(2'b10, 8'd0, 8'd7);
      check("max_done", outs(), pack(2'b10, 2'b10, 1'b1, 8'd0));
      step(2'b10, 8'd0, 8'd7);
      check("max_release", outs(), pack(2'b00, 2'b00, 1'b0, 8'd0));
      step(2'b10, 8'd0, 8'd7);
      check("max_new_len", outs(), pack(2'b10, 2'b00, 1'b1, 8'd7));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
